rr_grant_ctrl8: RTL

//   Round-robin arbiter that shares one 8-way one-hot-selected resource among 8 requesters.

---
 rtl/rr_grant_ctrl8.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/rr_grant_ctrl8.sv
// rr_grant_ctrl8: eight-way round-robin arbiter feeding a 3-to-8 decoder.
// Each grant is limited to MAX_HOLD cycles, and consecutive grants are
// separated by a GAP cycle followed by an IDLE cycle, so the decoder never
// sees two one-hot lines active in the same cycle.
//
//   state | meaning
//   ------+---------------------------------------------------------
//   IDLE  | no grant; arbitrate among pending requests on each edge
//   GRANT | gnt_idx owns the resource; hold_cnt counts cycles held
//   GAP   | break-before-make cycle after a release or a timeout
module rr_grant_ctrl8 #(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  output logic       gnt_vld,
  output logic [2:0] gnt_idx,
  output logic [7:0] gnt_oh,
  output logic       timeout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] hold_cnt;
  logic [CNT_W-1:0] hold_cnt_nxt;
  logic [2:0]       last;
  logic [2:0]       last_nxt;
  logic             gnt_vld_nxt;
  logic [2:0]       gnt_idx_nxt;
  logic [7:0]       gnt_oh_nxt;
  logic             timeout_nxt;

  logic [2:0]       cand;
  logic [2:0]       win_idx;
  logic             win_vld;
  logic             rel_vol;
  logic             rel_force;

  // Rotating priority search: start just after the last winner, wrap mod 8.
  // The eighth candidate is last itself, so a lone requester is re-granted.
  always_comb begin
    cand    = last;
    win_idx = last;
    win_vld = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      cand = last + 3'(i);
      if (!win_vld && req[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  // A dropped request wins over the hold limit when both happen on one edge.
  assign rel_vol   = !req[gnt_idx];
  assign rel_force = (hold_cnt == HOLD_MAX);

  // State and all output registers; reset forces priority back to index 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      gnt_vld  <= 1'b0;
      gnt_idx  <= 3'd7;
      gnt_oh   <= 8'h00;
      timeout  <= 1'b0;
      hold_cnt <= '0;
      last     <= 3'd7;
    end else begin
      state    <= state_nxt;
      gnt_vld  <= gnt_vld_nxt;
      gnt_idx  <= gnt_idx_nxt;
      gnt_oh   <= gnt_oh_nxt;
      timeout  <= timeout_nxt;
      hold_cnt <= hold_cnt_nxt;
      last     <= last_nxt;
    end
  end

  // Next-state transitions.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (win_vld) state_nxt = GRANT;
      GRANT:   if (rel_vol || rel_force) state_nxt = GAP;
      GAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values of the registered outputs, hold counter and priority pointer.
  always_comb begin
    gnt_vld_nxt  = gnt_vld;
    gnt_idx_nxt  = gnt_idx;
    gnt_oh_nxt   = gnt_oh;
    timeout_nxt  = 1'b0;
    hold_cnt_nxt = hold_cnt;
    last_nxt     = last;
    case (state)
      IDLE: begin
        if (win_vld) begin
          gnt_vld_nxt  = 1'b1;
          gnt_idx_nxt  = win_idx;
          gnt_oh_nxt   = 8'h01 << win_idx;
          last_nxt     = win_idx;
          hold_cnt_nxt = CNT_W'(1);
        end
      end
      GRANT: begin
        if (rel_vol) begin
          gnt_vld_nxt = 1'b0;
          gnt_oh_nxt  = 8'h00;
        end else if (rel_force) begin
          gnt_vld_nxt = 1'b0;
          gnt_oh_nxt  = 8'h00;
          timeout_nxt = 1'b1;
        end else begin
          hold_cnt_nxt = hold_cnt + CNT_W'(1);
        end
      end
      GAP: begin
        gnt_vld_nxt = 1'b0;
        gnt_oh_nxt  = 8'h00;
      end
      default: begin
        gnt_vld_nxt = 1'b0;
        gnt_oh_nxt  = 8'h00;
      end
    endcase
  end

endmodule
